// File: rtl/disp_mem_arb.sv
// Display memory arbiter: video fetches get every cycle they ask for with a fixed
// two-cycle read latency; host reads/writes are slotted into idle memory cycles.
module disp_mem_arb #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_sel_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic [DATA_W-1:0] vid_data_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic              host_ack_o,
  output logic              mem_sel_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // Host FSM state for checkers: 0 IDLE, 1 ISSUE, 2 RDATA, 3 ACK
  output logic [1:0]        host_state_o
);

  // Host handshake: host_req_i is a level held (with we/addr/wdata stable) until
  // the single-cycle host_ack_o; requests seen during the ack cycle are ignored.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2,
    ST_ACK   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic                sel_q, sel_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (host_req_i && !vid_sel_i) begin
          we_d    = host_we_i;
          sel_d   = 1'b1;
          wr_d    = host_we_i;
          addr_d  = host_addr_i;
          wdata_d = host_wdata_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = we_q ? ST_ACK : ST_RDATA;
      ST_RDATA: begin
        rdata_d = mem_rdata_i;
        state_d = ST_ACK;
      end
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Video overrides last; host issue above is already gated by !vid_sel_i,
    // so this only ever takes otherwise-idle cycles.
    if (vid_sel_i) begin
      sel_d  = 1'b1;
      wr_d   = 1'b0;
      addr_d = vid_addr_i;
    end
  end

  assign vid_data_o   = mem_rdata_i;
  assign host_rdata_o = rdata_q;
  assign host_ack_o   = (state_q == ST_ACK);
  assign mem_sel_o    = sel_q;
  assign mem_wr_o     = wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign host_state_o = state_q;

endmodule

// File: tb/tb_disp_mem_arb.sv
// Directed and randomized bench for disp_mem_arb with a synchronous SPRAM model
// and a word-level reference memory.
module tb_disp_mem_arb;

  logic        clk;
  logic        reset;
  logic        vid_sel;
  logic [15:0] vid_addr;
  logic [15:0] vid_data;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic [15:0] host_rdata;
  logic        host_ack;
  logic        mem_sel;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  host_state;

  logic [15:0] ram [0:65535];
  logic [15:0] ref_mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;

  disp_mem_arb #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .vid_sel_i    (vid_sel),
    .vid_addr_i   (vid_addr),
    .vid_data_o   (vid_data),
    .host_req_i   (host_req),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_rdata_o (host_rdata),
    .host_ack_o   (host_ack),
    .mem_sel_o    (mem_sel),
    .mem_wr_o     (mem_wr),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .host_state_o (host_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous single-port memory: read data valid the cycle after the strobe
  always @(posedge clk) begin
    if (mem_sel) begin
      if (mem_wr) ram[mem_addr] = mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic host_start(input logic we, input logic [15:0] a, input logic [15:0] d);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = a;
    host_wdata = d;
  endtask

  // soak state
  logic [15:0] vexp_q[$];
  int          vdue_q[$];
  logic        vid_pend;
  logic [15:0] vid_pend_addr;
  int          gap;
  int          wait_cnt;
  logic [15:0] va;

  initial begin
    reset = 1'b1; vid_sel = 1'b0; vid_addr = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    mem_rdata = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;

    // reset state
    tick(); tick();
    check("rst_mem_sel", mem_sel, 1'b0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_ack", host_ack, 1'b0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_wdata", mem_wdata, 16'h0000);
    check("rst_rdata", host_rdata, 16'h0000);
    check("rst_state", host_state, ST_IDLE);
    reset = 1'b0;
    tick();

    // video only
    ram[16'h0123] = 16'hBEEF;
    vid_sel = 1'b1; vid_addr = 16'h0123;
    tick();
    vid_sel = 1'b0; vid_addr = 16'h0000;
    check("vid_sel_n1", mem_sel, 1'b1);
    check("vid_addr_n1", mem_addr, 16'h0123);
    check("vid_wr_n1", mem_wr, 1'b0);
    tick();
    check("vid_data_n2", vid_data, 16'hBEEF);
    check("vid_sel_n2", mem_sel, 1'b0);
    tick();

    // host write then read
    host_start(1'b1, 16'h00FF, 16'h1234);
    tick();
    check("wr_sel_a1", mem_sel, 1'b1);
    check("wr_wr_a1", mem_wr, 1'b1);
    check("wr_addr_a1", mem_addr, 16'h00FF);
    check("wr_wdata_a1", mem_wdata, 16'h1234);
    check("wr_ack_a1", host_ack, 1'b0);
    tick();
    check("wr_ack_a2", host_ack, 1'b1);
    check("wr_wr_a2", mem_wr, 1'b0);
    host_req = 1'b0;
    tick();
    check("wr_ack_a3", host_ack, 1'b0);
    host_start(1'b0, 16'h00FF, 16'h0000);
    tick();
    check("rd_sel_a1", mem_sel, 1'b1);
    check("rd_wr_a1", mem_wr, 1'b0);
    check("rd_ack_a1", host_ack, 1'b0);
    tick();
    check("rd_ack_a2", host_ack, 1'b0);
    tick();
    check("rd_ack_a3", host_ack, 1'b1);
    check("rd_data_a3", host_rdata, 16'h1234);
    host_req = 1'b0;
    tick();

    // full-width address passthrough
    host_start(1'b1, 16'hFFFF, 16'hA5C3);
    tick();
    check("top_addr", mem_addr, 16'hFFFF);
    tick();
    host_req = 1'b0;
    tick();
    host_start(1'b0, 16'hFFFF, 16'h0000);
    tick(); tick(); tick();
    check("top_ack", host_ack, 1'b1);
    check("top_rdata", host_rdata, 16'hA5C3);
    host_req = 1'b0;
    tick();

    // collision: video wins, host follows
    ram[16'h0010] = 16'hAAAA;
    ram[16'h0020] = 16'h5555;
    host_start(1'b0, 16'h0010, 16'h0000);
    vid_sel = 1'b1; vid_addr = 16'h0020;
    tick();
    vid_sel = 1'b0;
    check("col_vid_addr", mem_addr, 16'h0020);
    check("col_vid_sel", mem_sel, 1'b1);
    tick();
    check("col_host_addr", mem_addr, 16'h0010);
    check("col_host_sel", mem_sel, 1'b1);
    check("col_vid_data", vid_data, 16'h5555);
    tick();
    check("col_ack_early", host_ack, 1'b0);
    tick();
    check("col_ack", host_ack, 1'b1);
    check("col_host_data", host_rdata, 16'hAAAA);
    host_req = 1'b0;
    tick();

    // video strobe while host read is in flight
    ram[16'h0030] = 16'h1111;
    ram[16'h0040] = 16'h2222;
    host_start(1'b0, 16'h0030, 16'h0000);
    tick();
    check("vdr_host_addr", mem_addr, 16'h0030);
    vid_sel = 1'b1; vid_addr = 16'h0040;
    tick();
    vid_sel = 1'b0;
    check("vdr_vid_addr", mem_addr, 16'h0040);
    check("vdr_vid_sel", mem_sel, 1'b1);
    tick();
    check("vdr_ack", host_ack, 1'b1);
    check("vdr_host_data", host_rdata, 16'h1111);
    check("vdr_vid_data", vid_data, 16'h2222);
    host_req = 1'b0;
    tick();
    check("vdr_rdata_hold", host_rdata, 16'h1111);

    // reset during RDATA drops the read
    ram[16'h0050] = 16'h7777;
    host_start(1'b0, 16'h0050, 16'h0000);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    host_req = 1'b0;
    check("rstrd_sel", mem_sel, 1'b0);
    check("rstrd_ack", host_ack, 1'b0);
    check("rstrd_state", host_state, ST_IDLE);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rstrd_no_ack", host_ack, 1'b0);
    end

    // reset kills an already registered video cycle
    vid_sel = 1'b1; vid_addr = 16'h0033;
    tick();
    vid_sel = 1'b0;
    check("rstv_sel_before", mem_sel, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstv_sel_after", mem_sel, 1'b0);
    tick();

    // soak: random host traffic against one video strobe per 6 cycles
    for (int i = 0; i < 256; i++) begin
      va = 16'($urandom);
      ram[i] = va;
      ref_mem[i] = va;
    end
    vid_pend = 1'b0;
    gap = 0;
    wait_cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (vid_pend) begin
        check("soak_vid_sel", mem_sel, 1'b1);
        check("soak_vid_wr", mem_wr, 1'b0);
        check("soak_vid_addr", mem_addr, vid_pend_addr);
        vid_pend = 1'b0;
      end
      if (vdue_q.size() > 0 && vdue_q[0] == cyc) begin
        void'(vdue_q.pop_front());
        va = vexp_q.pop_front();
        check("soak_vid_data", vid_data, ref_mem[va]);
      end
      if (host_req) begin
        if (host_ack) begin
          if (host_we) ref_mem[host_addr] = host_wdata;
          else         check("soak_host_rdata", host_rdata, ref_mem[host_addr]);
          host_req = 1'b0;
          gap = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
          if (wait_cnt >= 6) begin
            check("soak_ack_timeout", host_ack, 1'b1);
            host_req = 1'b0;
            gap = 8;
          end
        end
      end else begin
        check("soak_spurious_ack", host_ack, 1'b0);
      end

      vid_sel = (cyc % 6 == 0) && (c < 9990);
      vid_addr = 16'($urandom_range(0, 255));
      if (vid_sel) begin
        vid_pend = 1'b1;
        vid_pend_addr = vid_addr;
        vexp_q.push_back(vid_addr);
        vdue_q.push_back(cyc + 2);
      end
      if (!host_req) begin
        if (gap > 0) gap--;
        else if (c < 9990 && $urandom_range(0, 1) == 1) begin
          host_start(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom));
          wait_cnt = 0;
        end
      end
    end
    check("soak_vid_queue_drained", vdue_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/disp_mem_arb.md
# disp_mem_arb

Arbiter that shares the single-port display memory (16-bit words, 64K deep) between the video fetch engine (`video_gen`) and a host register/bus port. Video fetches have absolute priority and keep their fixed, stall-free read latency. Host reads and writes are slotted into idle memory cycles through a req/ack handshake. Sits between `video_gen`, the host bus interface and the display SPRAM/BRAM wrapper.

## Interface
- `ADDR_W`, 16, display memory word address width
- `DATA_W`, 16, display memory word width

- `clk`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `vid_sel_i`  in  1  video read strobe (`video_gen` `dispmem_sel_o`), one cycle per access
- `vid_addr_i`  in  ADDR_W  video read address, valid with `vid_sel_i`
- `vid_data_o`  out  DATA_W  video read data; wired directly to `mem_rdata_i`
- `host_req_i`  in  1  host request; level, held until `host_ack_o`
- `host_we_i`  in  1  1 = write, 0 = read; stable while `host_req_i` is high
- `host_addr_i`  in  ADDR_W  host word address
- `host_wdata_i`  in  DATA_W  host write data
- `host_rdata_o`  out  DATA_W  host read data, valid while `host_ack_o` is high after a read
- `host_ack_o`  out  1  one-cycle completion pulse
- `mem_sel_o`  out  1  memory access strobe (registered)
- `mem_wr_o`  out  1  memory write enable (registered, only with `mem_sel_o`)
- `mem_addr_o`  out  ADDR_W  memory address (registered)
- `mem_wdata_o`  out  DATA_W  memory write data (registered)
- `mem_rdata_i`  in  DATA_W  memory read data, valid the cycle after `mem_sel_o`

## Operation
- Memory outputs are registered. Each cycle the arbiter picks the next memory cycle from the requests present in the current cycle.
- Video priority: `vid_sel_i` high in cycle N gives `mem_sel_o`=1, `mem_wr_o`=0, `mem_addr_o`=`vid_addr_i` in cycle N+1. This holds unconditionally, whatever the host FSM state.
- Host FSM states: IDLE, ISSUE, RDATA, ACK.
  - IDLE: if `host_req_i`=1 and `vid_sel_i`=0:
    - latch we, addr and wdata;
    - drive the host memory cycle next cycle;
    - go to ISSUE.
  - IDLE, otherwise: stay in IDLE.
  - ISSUE (the host memory cycle is on the bus): go to RDATA if read, ACK if write.
  - RDATA: capture `mem_rdata_i` into `host_rdata_o`; go to ACK.
  - ACK: `host_ack_o`=1; ignore `host_req_i`; go to IDLE.
- Host memory cycles issue only from IDLE with `vid_sel_i` low, so a host cycle never collides with a video cycle.
- Idle memory cycles drive `mem_sel_o`=0, `mem_wr_o`=0. Address and data hold their last values.
- `host_rdata_o` holds its value until the next host read completes.
- Width rules: addresses pass through unmodified. There is no address arithmetic or wrap inside the block.

## Timing
- Reset values:
  - `mem_sel_o`, `mem_wr_o`, `host_ack_o` = 0
  - `mem_addr_o`, `mem_wdata_o`, `host_rdata_o` = 0
  - FSM in IDLE
- Video latency: strobe in cycle N, data on `vid_data_o` in cycle N+2. This matches `video_gen` ADDR→WAIT→READ sampling.
- Host write: req accepted in cycle A; memory write in A+1; `host_ack_o` in A+2.
- Host read: accepted in A; memory read in A+1; data captured at end of A+2; `host_ack_o` and `host_rdata_o` valid in A+3.
- After the ack cycle, the next request is sampled no earlier than the following cycle (minimum 3-cycle write / 4-cycle read throughput).
- Simultaneous `vid_sel_i` and `host_req_i` in IDLE: video wins and the host waits in IDLE.
- A video strobe during ISSUE/RDATA issues normally. Host read data on `mem_rdata_i` (A+2) precedes the video return (≥A+3), so neither is corrupted.
- Starvation bound: `video_gen` strobes at most once per 6 cycles, so a host request is accepted within 2 cycles of IDLE.
- `reset` mid-transaction: FSM returns to IDLE and the pending host access is dropped (no ack). Any memory cycle already registered is deasserted the next cycle. The requester must re-request.

## Test plan
- Reset: assert `reset` during a host read in RDATA. Required: next cycle `mem_sel_o`=0, `host_ack_o`=0, FSM IDLE, no ack ever issued for that read.
- Video only: `vid_sel_i` pulse with addr 0x0123, memory model returns 0xBEEF. Required: `mem_sel_o`/`mem_addr_o`=0x0123 at N+1, `vid_data_o`=0xBEEF at N+2, `mem_wr_o`=0.
- Host write then read: write 0x1234 to 0x00FF (ack at A+2, `mem_wr_o`=1 at A+1 only), then read 0x00FF. Required: ack at A+3 with `host_rdata_o`=0x1234.
- Collision: `host_req_i` (read 0x0010) and `vid_sel_i` (0x0020) rise in the same cycle. Required: the memory cycle goes to 0x0020 first and the host cycle to 0x0010 the cycle after. Video data and host data both correct.
- Video during host read: host read accepted at A, `vid_sel_i` at A+1. Required: memory sees host A+1 and video A+2; `host_rdata_o` is the host word, not the video word.
- Soak: 10,000 cycles of random host traffic against a `video_gen`-rate strobe pattern (1 per 6 cycles) with a scoreboard memory model. Required: zero data mismatches, no video latency deviation, every request acked within 6 cycles of assertion.
